// File: rtl/disk_if_pkg.sv
// Shared definitions for the host disk-request channel: op codes, disk_sr/disk_cr bit map,
// arbiter state encoding and the command-word helpers.
package disk_if_pkg;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SEEK  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   localparam int SR_ACK     = 16;
   localparam int SR_RD0     = 17;
   localparam int SR_RD1     = 18;
   localparam int SR_WR0     = 20;
   localparam int SR_WR1     = 21;
   localparam int SR_SEEK_LO = 24;

   localparam int CR_DONE = 4;
   localparam int CR_ERR  = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_RELEASE,
      ST_WAIT_LOW
   } state_t;

   // addr = {drive, head, cyl[6:0], sector[7:0]}
   typedef struct packed {
      logic [1:0]  op;
      logic [16:0] addr;
   } disk_cmd_t;

   function automatic logic [31:0] encode_cmd(input disk_cmd_t c);
      logic [31:0] w;
      w       = '0;
      w[15:0] = c.addr[15:0];
      case (c.op)
         OP_READ:  w[c.addr[16] ? SR_RD1 : SR_RD0] = 1'b1;
         OP_WRITE: w[c.addr[16] ? SR_WR1 : SR_WR0] = 1'b1;
         OP_SEEK:  w[SR_SEEK_LO +: 2] = c.addr[16] ? 2'b10 : 2'b01;
         default:  w = '0;
      endcase
      return w;
   endfunction

   // Drop the command bits but keep the address visible, and raise ack-of-ack.
   function automatic logic [31:0] release_word(input logic [31:0] w_in);
      logic [31:0] w;
      w                 = w_in;
      w[SR_RD0]         = 1'b0;
      w[SR_RD1]         = 1'b0;
      w[SR_WR0]         = 1'b0;
      w[SR_WR1]         = 1'b0;
      w[SR_SEEK_LO +: 2] = 2'b00;
      w[SR_ACK]         = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/disk_req_arbiter_rr_arb2.sv
// Two-way round-robin picker: the requester that did not win last time wins a tie.
// Combinational pick; last-grant register updated only when the caller says a grant finished.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_grant,
   output logic       pick,
   output logic       any
);

   logic last;

   assign any  = |req;
   assign pick = (&req) ? ~last : req[1];

   // Reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n)
         last <= 1'b1;
      else if (upd)
         last <= upd_grant;
   end

endmodule

// File: rtl/disk_req_arbiter.sv
// Shares the host disk_sr/disk_cr channel between two controllers, one command in flight.
// valid->ready 1 cycle, host done->rq done 1 cycle; valid must be held while the channel is busy.
module disk_req_arbiter
   import disk_if_pkg::*;
#(
   parameter int                   TIMEOUT_W      = 24,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd8000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rq0_valid,
   input  logic        rq1_valid,
   input  logic [1:0]  rq0_op,
   input  logic [1:0]  rq1_op,
   input  logic [16:0] rq0_addr,
   input  logic [16:0] rq1_addr,
   output logic        rq0_ready,
   output logic        rq1_ready,
   output logic        rq0_done,
   output logic        rq1_done,
   output logic        rq0_err,
   output logic        rq1_err,
   output logic        rq0_din_wr,
   output logic        rq1_din_wr,
   output logic        rq0_dout_rd,
   output logic        rq1_dout_rd,
   input  logic        disk_data_clkin,
   input  logic        disk_data_clkout,
   output logic [31:0] disk_sr,
   input  logic [31:0] disk_cr,
   output logic        grant,
   output logic        busy
);

   localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_CYCLES - 1'b1;

   state_t               state;
   disk_cmd_t            cmd;
   logic [31:0]          sr_q;
   logic [TIMEOUT_W-1:0] wd;
   logic [1:0]           ready_q;
   logic [1:0]           done_q;
   logic [1:0]           err_q;
   logic                 arb_pick;
   logic                 arb_any;
   logic                 last_upd;
   logic                 host_done;
   logic                 unused_cr;

   assign host_done = disk_cr[CR_DONE];
   assign unused_cr = ^{disk_cr[31:CR_DONE+1], disk_cr[CR_ERR-1:0]};

   assign last_upd = (state == ST_RELEASE) || (state == ST_ISSUE && cmd.op == OP_RSVD);

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       ({rq1_valid, rq0_valid}),
      .upd       (last_upd),
      .upd_grant (grant),
      .pick      (arb_pick),
      .any       (arb_any)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cmd     <= '0;
         sr_q    <= '0;
         wd      <= '0;
         grant   <= 1'b0;
         ready_q <= '0;
         done_q  <= '0;
         err_q   <= '0;
      end else begin
         ready_q <= '0;
         done_q  <= '0;
         err_q   <= '0;
         unique case (state)
            ST_IDLE: begin
               // A done still high from the previous command would be mistaken for the next one.
               if (arb_any && !host_done) begin
                  grant            <= arb_pick;
                  ready_q[arb_pick] <= 1'b1;
                  cmd              <= arb_pick ? {rq1_op, rq1_addr} : {rq0_op, rq0_addr};
                  state            <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (cmd.op == OP_RSVD) begin
                  done_q[grant] <= 1'b1;
                  err_q[grant]  <= 1'b1;
                  state         <= ST_IDLE;
               end else begin
                  sr_q  <= encode_cmd(cmd);
                  wd    <= '0;
                  state <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               wd <= wd + 1'b1;
               // Done takes priority over a coincident timeout.
               if (host_done || wd == WD_LAST) begin
                  done_q[grant] <= 1'b1;
                  err_q[grant]  <= host_done ? disk_cr[CR_ERR] : 1'b1;
                  sr_q          <= release_word(sr_q);
                  state         <= ST_RELEASE;
               end
            end
            ST_RELEASE: state <= ST_WAIT_LOW;
            ST_WAIT_LOW: begin
               if (!host_done)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy    = (state != ST_IDLE);
   assign disk_sr = sr_q;

   assign rq0_ready = ready_q[0];
   assign rq1_ready = ready_q[1];
   assign rq0_done  = done_q[0];
   assign rq1_done  = done_q[1];
   assign rq0_err   = err_q[0];
   assign rq1_err   = err_q[1];

   // Strobes keep flowing through WAIT_LOW so the controller can drain its byte FIFO.
   assign rq0_din_wr  = disk_data_clkin  & busy & ~grant;
   assign rq1_din_wr  = disk_data_clkin  & busy &  grant;
   assign rq0_dout_rd = disk_data_clkout & busy & ~grant;
   assign rq1_dout_rd = disk_data_clkout & busy &  grant;

endmodule
